// File: rtl/ulpi_link_debug.sv
// ULPI link-side debug controller: PHY reset stretcher, register read/write
// sequencer with PHY-abort replay and timeout, and RX CMD capture.
module ulpi_link_debug #(
  parameter int RST_CYCLES = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic       ulpi_clk,
  input  logic       rst_btn,
  output logic       ulpi_rst,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_in,
  output logic       ulpi_stp,
  output logic [7:0] ulpi_data_out,
  input  logic       reg_req,
  input  logic       reg_we,
  input  logic [5:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic       reg_ack,
  output logic       reg_err,
  output logic [7:0] reg_rdata,
  output logic [7:0] rxcmd,
  output logic       rxcmd_vld
);

  localparam logic [7:0]  RST_LIM = 8'(RST_CYCLES);
  localparam logic [11:0] TO_LIM  = 12'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    RST, IDLE, CMD, WDATA, STP, RTURN, RDATA, REND
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  sync_reg;
  logic [7:0]  rst_cnt_reg;
  logic [11:0] tcnt_reg;
  logic        pend_reg, pend_next;
  logic        we_reg;
  logic [5:0]  addr_reg;
  logic [7:0]  wdata_reg;
  logic        ack_reg, ack_next;
  logic        err_reg, err_next;
  logic [7:0]  rdata_reg;
  logic [7:0]  rxcmd_reg;
  logic        rxcmd_vld_reg;
  logic        dir_prev_reg;
  logic        latch;
  logic        timeout_hit;
  logic        rx_hit;

  // Deassertion is synchronised before the stretch counter starts.
  always_ff @(posedge ulpi_clk or negedge rst_btn) begin
    if (!rst_btn) begin
      sync_reg    <= 2'b00;
      rst_cnt_reg <= 8'd0;
    end else begin
      sync_reg <= {sync_reg[0], 1'b1};
      if (!sync_reg[1])
        rst_cnt_reg <= 8'd0;
      else if (rst_cnt_reg != RST_LIM)
        rst_cnt_reg <= rst_cnt_reg + 8'd1;
    end
  end

  assign ulpi_rst    = !(sync_reg[1] && (rst_cnt_reg == RST_LIM));
  assign timeout_hit = (tcnt_reg == TO_LIM);
  // The read-data cycle looks like an RX CMD on the bus and must not be taken as one.
  assign rx_hit      = ulpi_dir && !ulpi_nxt && dir_prev_reg && (state_reg != RDATA);

  always_comb begin
    state_next    = state_reg;
    pend_next     = pend_reg;
    latch         = 1'b0;
    ack_next      = 1'b0;
    err_next      = 1'b0;
    ulpi_stp      = 1'b0;
    ulpi_data_out = 8'h00;
    if (ulpi_rst) begin
      state_next = RST;
    end else begin
      case (state_reg)
        RST: state_next = IDLE;
        IDLE: begin
          if (reg_req && !pend_reg) begin
            latch     = 1'b1;
            pend_next = 1'b1;
          end
          if ((reg_req || pend_reg) && !ulpi_dir)
            state_next = CMD;
        end
        CMD: begin
          ulpi_data_out = {1'b1, !we_reg, addr_reg};
          if (ulpi_dir) begin
            state_next = IDLE;   // pend stays set so the access is replayed
          end else if (timeout_hit) begin
            state_next = IDLE;
            err_next   = 1'b1;
            pend_next  = 1'b0;
          end else if (ulpi_nxt) begin
            state_next = we_reg ? WDATA : RTURN;
          end
        end
        WDATA: begin
          ulpi_data_out = wdata_reg;
          if (ulpi_dir) begin
            state_next = IDLE;
          end else if (timeout_hit) begin
            state_next = IDLE;
            err_next   = 1'b1;
            pend_next  = 1'b0;
          end else if (ulpi_nxt) begin
            state_next = STP;
            ack_next   = 1'b1;
            pend_next  = 1'b0;
          end
        end
        STP: begin
          ulpi_stp   = 1'b1;
          state_next = IDLE;
        end
        RTURN: begin
          if (timeout_hit) begin
            state_next = IDLE;
            err_next   = 1'b1;
            pend_next  = 1'b0;
          end else if (ulpi_dir) begin
            state_next = RDATA;
          end
        end
        RDATA: begin
          state_next = REND;
          ack_next   = 1'b1;
          pend_next  = 1'b0;
        end
        REND: begin
          if (!ulpi_dir)
            state_next = IDLE;
        end
        default: state_next = RST;
      endcase
    end
  end

  always_ff @(posedge ulpi_clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_reg     <= RST;
      pend_reg      <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= 6'd0;
      wdata_reg     <= 8'h00;
      ack_reg       <= 1'b0;
      err_reg       <= 1'b0;
      rdata_reg     <= 8'h00;
      rxcmd_reg     <= 8'h00;
      rxcmd_vld_reg <= 1'b0;
      dir_prev_reg  <= 1'b0;
      tcnt_reg      <= 12'd0;
    end else begin
      state_reg     <= state_next;
      pend_reg      <= pend_next;
      ack_reg       <= ack_next;
      err_reg       <= err_next;
      dir_prev_reg  <= ulpi_dir;
      rxcmd_vld_reg <= rx_hit;
      if (latch) begin
        we_reg    <= reg_we;
        addr_reg  <= reg_addr;
        wdata_reg <= reg_wdata;
      end
      if (state_reg == RDATA)
        rdata_reg <= ulpi_data_in;
      if (rx_hit)
        rxcmd_reg <= ulpi_data_in;
      if (state_reg == IDLE && state_next == CMD)
        tcnt_reg <= 12'd0;
      else if (state_reg != IDLE && state_reg != RST && tcnt_reg != TO_LIM)
        tcnt_reg <= tcnt_reg + 12'd1;
    end
  end

  assign reg_ack   = ack_reg;
  assign reg_err   = err_reg;
  assign reg_rdata = rdata_reg;
  assign rxcmd     = rxcmd_reg;
  assign rxcmd_vld = rxcmd_vld_reg;

endmodule

// File: tb/tb_ulpi_link_debug.sv
// Self-checking bench for ulpi_link_debug: vector table, hand sequences for
// abort/timeout/reset, and randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_ulpi_link_debug;

  localparam int RST_CYCLES = 16;
  localparam int TIMEOUT    = 255;

  logic       ulpi_clk;
  logic       rst_btn;
  logic       ulpi_rst;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic [7:0] ulpi_data_in;
  logic       ulpi_stp;
  logic [7:0] ulpi_data_out;
  logic       reg_req;
  logic       reg_we;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_ack;
  logic       reg_err;
  logic [7:0] reg_rdata;
  logic [7:0] rxcmd;
  logic       rxcmd_vld;

  ulpi_link_debug #(.RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .ulpi_clk(ulpi_clk), .rst_btn(rst_btn), .ulpi_rst(ulpi_rst),
    .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_data_in(ulpi_data_in),
    .ulpi_stp(ulpi_stp), .ulpi_data_out(ulpi_data_out),
    .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata),
    .rxcmd(rxcmd), .rxcmd_vld(rxcmd_vld)
  );

  initial ulpi_clk = 1'b0;
  always #5 ulpi_clk = ~ulpi_clk;

  typedef struct {
    logic       we;
    logic [5:0] addr;
    logic [7:0] data;
    int         dly;
    logic [7:0] exp_cmd;
  } vec_t;

  vec_t vecs[8];
  int tests = 0;
  int fails = 0;
  int ack_cnt = 0, err_cnt = 0, vld_cnt = 0, both_cnt = 0;
  int exp_acks = 0, exp_errs = 0, exp_vlds = 0;
  logic [7:0] exp_rdata = 8'h00;
  logic [7:0] exp_rxcmd = 8'h00;

  always @(negedge ulpi_clk) begin
    if (reg_ack === 1'b1) ack_cnt++;
    if (reg_err === 1'b1) err_cnt++;
    if (rxcmd_vld === 1'b1) vld_cnt++;
    if (reg_ack === 1'b1 && reg_err === 1'b1) both_cnt++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge ulpi_clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Command byte from the access type: 0x80 base for writes, 0xC0 for reads.
  function automatic logic [7:0] model_cmd(input logic we, input logic [5:0] a);
    int v;
    v = (we ? 128 : 192) + int'(a);
    return v[7:0];
  endfunction

  task automatic release_and_measure(input string nm);
    int n;
    n = 0;
    rst_btn = 1'b1;
    while (ulpi_rst !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    check(nm, n, RST_CYCLES + 2);
    tick();
  endtask

  task automatic issue(input logic we, input logic [5:0] a, input logic [7:0] d);
    $display("[TB] %s addr=%h data=%h", we ? "write" : "read", a, d);
    reg_req = 1'b1; reg_we = we; reg_addr = a; reg_wdata = d;
    tick();
    reg_req = 1'b0;
  endtask

  task automatic finish_write(input logic [7:0] d, input int dly, input logic [7:0] exp_cmd);
    for (int i = 0; i < dly; i++) begin
      check("cmd_hold", ulpi_data_out, exp_cmd);
      tick();
    end
    check("cmd", ulpi_data_out, exp_cmd);
    ulpi_nxt = 1'b1; tick(); ulpi_nxt = 1'b0;
    for (int i = 0; i < dly; i++) begin
      check("wdata_hold", ulpi_data_out, d);
      tick();
    end
    check("wdata", ulpi_data_out, d);
    check("wdata_stp", ulpi_stp, 1'b0);
    ulpi_nxt = 1'b1; tick(); ulpi_nxt = 1'b0;
    check("stp", ulpi_stp, 1'b1);
    check("stp_data", ulpi_data_out, 8'h00);
    check("wr_ack", reg_ack, 1'b1);
    check("wr_err", reg_err, 1'b0);
    tick();
    check("post_stp", ulpi_stp, 1'b0);
    check("ack_pulse", reg_ack, 1'b0);
    exp_acks++;
  endtask

  task automatic finish_read(input logic [7:0] rd, input int dly, input logic [7:0] exp_cmd);
    for (int i = 0; i < dly; i++) begin
      check("cmd_hold", ulpi_data_out, exp_cmd);
      tick();
    end
    check("cmd", ulpi_data_out, exp_cmd);
    ulpi_nxt = 1'b1; tick(); ulpi_nxt = 1'b0;
    check("rturn_data", ulpi_data_out, 8'h00);
    ulpi_dir = 1'b1; ulpi_data_in = 8'($urandom); tick();
    ulpi_data_in = rd;
    check("rdata_early_ack", reg_ack, 1'b0);
    tick();
    ulpi_dir = 1'b0; ulpi_data_in = 8'h00;
    check("rd_ack", reg_ack, 1'b1);
    check("rdata", reg_rdata, rd);
    check("rd_no_rxcmd", rxcmd_vld, 1'b0);
    tick();
    check("rend_idle", ulpi_data_out, 8'h00);
    check("rd_ack_pulse", reg_ack, 1'b0);
    exp_acks++;
    exp_rdata = rd;
  endtask

  task automatic rx_burst(input logic [7:0] b, input int pkts);
    $display("[TB] rxcmd byte=%h pkts=%0d", b, pkts);
    ulpi_dir = 1'b1; ulpi_nxt = 1'b0; ulpi_data_in = 8'($urandom); tick();
    for (int p = 0; p < pkts; p++) begin
      ulpi_nxt = 1'b1; ulpi_data_in = 8'($urandom); tick();
      check("pkt_no_rxcmd", rxcmd, exp_rxcmd);
    end
    ulpi_nxt = 1'b0; ulpi_data_in = b; tick();
    ulpi_dir = 1'b0; ulpi_data_in = 8'h00;
    check("rxcmd_vld", rxcmd_vld, 1'b1);
    check("rxcmd", rxcmd, b);
    tick();
    check("rxcmd_vld_pulse", rxcmd_vld, 1'b0);
    exp_rxcmd = b;
    exp_vlds++;
  endtask

  initial begin
    int n;
    logic       r_we;
    logic [5:0] r_addr;
    logic [7:0] r_data;
    int         r_dly;

    vecs[0] = '{1'b1, 6'h0A, 8'h55, 1, 8'h8A};
    vecs[1] = '{1'b0, 6'h16, 8'h24, 0, 8'hD6};
    vecs[2] = '{1'b1, 6'h3F, 8'hFF, 2, 8'hBF};
    vecs[3] = '{1'b0, 6'h00, 8'h81, 3, 8'hC0};
    vecs[4] = '{1'b1, 6'h00, 8'h00, 0, 8'h80};
    vecs[5] = '{1'b0, 6'h3F, 8'hA5, 1, 8'hFF};
    vecs[6] = '{1'b1, 6'h15, 8'h0F, 0, 8'h95};
    vecs[7] = '{1'b0, 6'h2A, 8'h5A, 2, 8'hEA};

    rst_btn = 1'b0; ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_in = 8'h00;
    reg_req = 1'b0; reg_we = 1'b0; reg_addr = 6'd0; reg_wdata = 8'h00;
    tick(); tick(); tick();
    check("rst_ulpi_rst", ulpi_rst, 1'b1);
    check("rst_stp", ulpi_stp, 1'b0);
    check("rst_data_out", ulpi_data_out, 8'h00);
    check("rst_ack", reg_ack, 1'b0);
    check("rst_err", reg_err, 1'b0);
    check("rst_rdata", reg_rdata, 8'h00);
    check("rst_rxcmd", rxcmd, 8'h00);
    check("rst_rxcmd_vld", rxcmd_vld, 1'b0);
    release_and_measure("rst_stretch");
    check("idle_data_out", ulpi_data_out, 8'h00);

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].we, vecs[i].addr, vecs[i].data);
      if (vecs[i].we)
        finish_write(vecs[i].data, vecs[i].dly, vecs[i].exp_cmd);
      else
        finish_read(vecs[i].data, vecs[i].dly, vecs[i].exp_cmd);
      check("rdata_hold", reg_rdata, exp_rdata);
    end

    // Request arriving while the PHY owns the bus waits for dir to drop.
    $display("[TB] write addr=31 data=c3 while dir=1");
    ulpi_dir = 1'b1; ulpi_nxt = 1'b1;
    reg_req = 1'b1; reg_we = 1'b1; reg_addr = 6'h31; reg_wdata = 8'hC3;
    tick();
    reg_req = 1'b0;
    check("held_idle0", ulpi_data_out, 8'h00);
    tick();
    check("held_idle1", ulpi_data_out, 8'h00);
    ulpi_dir = 1'b0; ulpi_nxt = 1'b0;
    tick();
    finish_write(8'hC3, 0, 8'hB1);

    // PHY takes the bus during CMD, sends an RX CMD, then the write is replayed.
    issue(1'b1, 6'h04, 8'hAA);
    check("abort_cmd", ulpi_data_out, 8'h84);
    ulpi_dir = 1'b1; ulpi_data_in = 8'h11; tick();
    ulpi_data_in = 8'h4E; tick();
    ulpi_dir = 1'b0; ulpi_data_in = 8'h00;
    check("abort_idle", ulpi_data_out, 8'h00);
    check("abort_rxcmd", rxcmd, 8'h4E);
    check("abort_rxcmd_vld", rxcmd_vld, 1'b1);
    check("abort_no_ack", reg_ack, 1'b0);
    exp_rxcmd = 8'h4E;
    exp_vlds++;
    tick();
    finish_write(8'hAA, 1, 8'h84);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0)
        rx_burst(8'($urandom), int'($urandom_range(0, 2)));
      r_we   = 1'($urandom_range(0, 1));
      r_addr = 6'($urandom);
      r_data = 8'($urandom);
      r_dly  = int'($urandom_range(0, 3));
      issue(r_we, r_addr, r_data);
      if (r_we)
        finish_write(r_data, r_dly, model_cmd(r_we, r_addr));
      else
        finish_read(r_data, r_dly, model_cmd(r_we, r_addr));
      check("rand_rdata_hold", reg_rdata, exp_rdata);
      check("rand_rxcmd_hold", rxcmd, exp_rxcmd);
    end

    // Read whose command is never accepted by the PHY.
    issue(1'b0, 6'h11, 8'h00);
    n = 0;
    while (reg_err !== 1'b1 && n < TIMEOUT + 100) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, TIMEOUT);
    check("timeout_no_ack", reg_ack, 1'b0);
    check("timeout_idle", ulpi_data_out, 8'h00);
    exp_errs++;
    tick();
    check("timeout_err_pulse", reg_err, 1'b0);
    check("timeout_rdata_hold", reg_rdata, exp_rdata);

    // Reset asserted in the middle of a write data phase.
    issue(1'b1, 6'h2A, 8'h3C);
    ulpi_nxt = 1'b1; tick(); ulpi_nxt = 1'b0;
    check("mid_wdata", ulpi_data_out, 8'h3C);
    rst_btn = 1'b0;
    #1;
    check("mid_rst_ulpi_rst", ulpi_rst, 1'b1);
    check("mid_rst_stp", ulpi_stp, 1'b0);
    check("mid_rst_data_out", ulpi_data_out, 8'h00);
    check("mid_rst_ack", reg_ack, 1'b0);
    check("mid_rst_err", reg_err, 1'b0);
    check("mid_rst_rdata", reg_rdata, 8'h00);
    check("mid_rst_rxcmd", rxcmd, 8'h00);
    check("mid_rst_vld", rxcmd_vld, 1'b0);
    exp_rdata = 8'h00;
    exp_rxcmd = 8'h00;
    tick(); tick();
    release_and_measure("mid_rst_stretch");
    for (int i = 0; i < 6; i++) begin
      check("no_replay_data", ulpi_data_out, 8'h00);
      tick();
    end

    check("ack_total", ack_cnt, exp_acks);
    check("err_total", err_cnt, exp_errs);
    check("rxcmd_vld_total", vld_cnt, exp_vlds);
    check("ack_err_overlap", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ulpi_link_debug.md
ULPI_LINK_DEBUG -- requirements
Module: ulpi_link_debug

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: ulpi_clk cycles ulpi_rst is held after rst_btn release (range 2..255).
REQ-002 SHALL have parameter TIMEOUT, default 255: max cycles per register access before abort (range 8..4095).
REQ-003 SHALL have ports: ulpi_clk in 1, clock, all logic on rising edge.
REQ-004 SHALL have port rst_btn  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have port ulpi_rst  out  1: stretched reset to ulpi_io.
REQ-006 SHALL have ports ulpi_dir, ulpi_nxt  in  1 each: PHY direction and next, from ulpi_io.
REQ-007 SHALL have port ulpi_data_in  in  8: PHY-to-link data.
REQ-008 SHALL have ports ulpi_stp  out  1 and ulpi_data_out  out  8: link-to-PHY stop and data.
REQ-009 SHALL have ports reg_req in 1, reg_we in 1, reg_addr in 6, reg_wdata in 8: register access request.
REQ-010 SHALL have ports reg_ack out 1, reg_err out 1, reg_rdata out 8: access completion, one-cycle pulse.
REQ-011 SHALL have ports rxcmd out 8, rxcmd_vld out 1: last RX CMD byte and its one-cycle strobe.

Function
REQ-012 Reset stretch: ulpi_rst SHALL be 1 while rst_btn=0 and for exactly RST_CYCLES ulpi_clk edges after a 2-flop synchronised deassertion; counter saturates, no wrap.
REQ-013 FSM states: RST, IDLE, CMD, WDATA, STP, RTURN, RDATA, REND; ulpi_rst=1 forces RST; RST->IDLE when ulpi_rst=0.
REQ-014 IDLE: ulpi_data_out=0x00, ulpi_stp=0; reg_req=1 with ulpi_dir=0 SHALL latch reg_we/addr/wdata and go to CMD next cycle; reg_req while dir=1 is held until dir=0.
REQ-015 CMD: ulpi_data_out SHALL be {2'b10,addr} for write, {2'b11,addr} for read, held until ulpi_nxt=1.
REQ-016 CMD with nxt=1 and dir=0: write -> WDATA, read -> RTURN.
REQ-017 WDATA: ulpi_data_out=wdata held until nxt=1, then STP.
REQ-018 STP: ulpi_stp=1, ulpi_data_out=0x00 for exactly one cycle; reg_ack pulses in the same cycle; next state IDLE.
REQ-019 RTURN: ulpi_data_out=0x00; requires dir=1 (turnaround cycle, data ignored), then RDATA.
REQ-020 RDATA: ulpi_data_in SHALL be captured into reg_rdata, reg_ack pulses, go to REND.
REQ-021 REND: wait for dir=0 (turnaround), then IDLE; no ulpi_data_out drive other than 0x00.
REQ-022 PHY abort: dir rising while in CMD or WDATA SHALL abandon the access, return to IDLE, and re-issue the same latched access automatically once dir=0; no ack/err pulse.
REQ-023 Timeout: a cycle counter SHALL clear on entering CMD and count every non-IDLE cycle; reaching TIMEOUT SHALL pulse reg_err, drop the access, go to IDLE (from REND only after dir=0).
REQ-024 reg_ack and reg_err SHALL never be 1 in the same cycle; exactly one of them per accepted request.
REQ-025 RX CMD: in any state, cycle with dir=1, nxt=0, and dir=1 on previous cycle (not turnaround) SHALL load rxcmd=ulpi_data_in and pulse rxcmd_vld; RDATA cycle of a register read SHALL NOT be treated as RX CMD.
REQ-026 dir=1 with nxt=1 (packet data) SHALL not affect rxcmd.
REQ-027 reg_rdata SHALL hold its value until the next successful read.

Reset
REQ-028 On rst_btn=0, asynchronously: FSM=RST, ulpi_rst=1, ulpi_stp=0, ulpi_data_out=0x00, reg_ack=0, reg_err=0, reg_rdata=0x00, rxcmd=0x00, rxcmd_vld=0, counters=0.
REQ-029 Reset mid-access SHALL discard the access without ack/err; the request is not replayed.

Verification
REQ-030 Release rst_btn -> ulpi_rst=1 for exactly 16 cycles after sync, then 0; FSM in IDLE.
REQ-031 Write addr 0x0A data 0x55, PHY nxt 1 cycle after each drive -> data_out 0x8A, 0x55, then stp=1 with 0x00 one cycle, reg_ack pulse.
REQ-032 Read addr 0x16, PHY nxt, dir=1 turnaround, data 0x24, dir=0 -> data_out 0xD6, reg_rdata=0x24, one reg_ack, no rxcmd_vld.
REQ-033 dir rises during CMD of write 0x04/0xAA, PHY sends RX CMD 0x4E, dir falls -> rxcmd=0x4E with one rxcmd_vld, write re-issued, single reg_ack.
REQ-034 Read with PHY never asserting nxt -> reg_err pulse at cycle 255 after entering CMD, no reg_ack, IDLE afterwards.
REQ-035 rst_btn=0 during WDATA -> all outputs at REQ-028 values immediately, no ack/err after release.
